// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush scheduler with MDU sequencing and exception redirect ordering
// Optional: define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic       id_md_use,
    input  logic [4:0] ex_rw,
    input  logic       ex_regWrite,
    input  logic       ex_memRead,
    input  logic [4:0] mem_rw,
    input  logic       mem_memRead,
    input  logic       md_start,
    input  logic       md_is_div,
    input  logic       exc_req,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_ex,
    output logic       flush_id,
    output logic       md_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;
    typedef enum logic {EX_NORM, EX_HOLD} ex_state_t;

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    md_state_t        md_state_q, md_state_d;
    ex_state_t        ex_state_q, ex_state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    logic match_ex, match_mem;
    logic hz_load, hz_branch, hz_md, hazard;

    // $0 is hardwired, so a write to it never produces a dependency
    assign match_ex  = (ex_rw != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_rw)) || (id_use_rt && (id_rt == ex_rw)));
    assign match_mem = (mem_rw != 5'd0) &&
                       ((id_use_rs && (id_rs == mem_rw)) || (id_use_rt && (id_rt == mem_rw)));

    assign hz_load   = ex_memRead && match_ex;
    assign hz_branch = id_is_branch && ((ex_regWrite && match_ex) || (mem_memRead && match_mem));
    assign hz_md     = id_md_use && md_busy;
    assign hazard    = hz_load | hz_branch | hz_md;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_state_q <= MD_IDLE;
            md_cnt_q   <= '0;
            ex_state_q <= EX_NORM;
        end else begin
            md_state_q <= md_state_d;
            md_cnt_q   <= md_cnt_d;
            ex_state_q <= ex_state_d;
        end
    end

    always_comb begin
        md_state_d = md_state_q;
        md_cnt_d   = md_cnt_q;
        ex_state_d = ex_state_q;
        case (md_state_q)
            MD_IDLE, MD_DONE: begin
                if (md_start) begin
                    md_state_d = MD_BUSY;
                    md_cnt_d   = md_is_div ? DIV_LOAD : MUL_LOAD;
                end else begin
                    md_state_d = MD_IDLE;
                end
            end
            MD_BUSY: begin
                md_cnt_d = md_cnt_q - CNT_ONE;
                if (md_cnt_q == CNT_ONE) begin
                    md_state_d = MD_DONE;
                end
            end
            default: md_state_d = MD_IDLE;
        endcase
        // HOLD swallows the repeat request of the instruction that raised the redirect
        case (ex_state_q)
            EX_NORM: if (exc_req && !hazard) ex_state_d = EX_HOLD;
            default: ex_state_d = EX_NORM;
        endcase
    end

    // Reset gates the combinational outputs so they fall without waiting for a clock
    always_comb begin
        md_busy  = (md_state_q == MD_BUSY);
        flush_id = rst && (ex_state_q == EX_NORM) && exc_req && !hazard;
        stall_if = rst && hazard && !flush_id;
        stall_id = stall_if;
        flush_ex = stall_if;
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_id && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_id && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rw, mem_rw;
    logic       id_use_rs, id_use_rt, id_is_branch, id_md_use;
    logic       ex_regWrite, ex_memRead, mem_memRead;
    logic       md_start, md_is_div, exc_req;
    logic       stall_if, stall_id, flush_ex, flush_id, md_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_md_use    (id_md_use),
        .ex_rw        (ex_rw),
        .ex_regWrite  (ex_regWrite),
        .ex_memRead   (ex_memRead),
        .mem_rw       (mem_rw),
        .mem_memRead  (mem_memRead),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .exc_req      (exc_req),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_ex     (flush_ex),
        .flush_id     (flush_id),
        .md_busy      (md_busy)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic s, input logic f);
        chk({tag, "_stall_if"}, 32'(stall_if), 32'(s));
        chk({tag, "_stall_id"}, 32'(stall_id), 32'(s));
        chk({tag, "_flush_ex"}, 32'(flush_ex), 32'(s));
        chk({tag, "_flush_id"}, 32'(flush_id), 32'(f));
    endtask

    task automatic clr_in();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
        id_is_branch = 0; id_md_use = 0;
        ex_rw = '0; ex_regWrite = 0; ex_memRead = 0;
        mem_rw = '0; mem_memRead = 0;
        md_start = 0; md_is_div = 0; exc_req = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        clr_in();
        cyc();
        cyc();
        // hazard and exception inputs present while in reset: outputs must stay low
        ex_memRead = 1; ex_rw = 5'd3; id_rs = 5'd3; id_use_rs = 1; exc_req = 1;
        #1;
        chk_out("rst_in", 0, 0);
        chk("rst_busy", 32'(md_busy), 0);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        clr_in();
        rst = 1'b1;
        @(negedge clk); chk_out("idle", 0, 0);

        // load-use
        cyc(); ex_memRead = 1; ex_rw = 5'd3; id_rs = 5'd3; id_use_rs = 1;
        @(negedge clk); chk_out("ld_rs", 1, 0);
        cyc(); ex_memRead = 0; ex_rw = 5'd0; mem_memRead = 1; mem_rw = 5'd3;
        @(negedge clk); chk_out("ld_mem", 0, 0);
        cyc(); clr_in(); ex_memRead = 1; ex_rw = 5'd7; id_rt = 5'd7; id_use_rt = 1;
        @(negedge clk); chk_out("ld_rt", 1, 0);
        cyc(); id_use_rt = 0;
        @(negedge clk); chk_out("ld_noen", 0, 0);
        cyc(); clr_in(); ex_memRead = 1; ex_rw = 5'd0; id_rs = 5'd0; id_use_rs = 1;
        @(negedge clk); chk_out("ld_r0", 0, 0);
        cyc(); clr_in(); ex_regWrite = 1; ex_rw = 5'd3; id_rs = 5'd3; id_use_rs = 1;
        @(negedge clk); chk_out("alu_fwd", 0, 0);

        // branch in ID
        cyc(); id_is_branch = 1; id_rs = 5'd5; ex_rw = 5'd5;
        @(negedge clk); chk_out("br_alu_ex", 1, 0);
        cyc(); ex_regWrite = 0; ex_rw = 5'd0; mem_rw = 5'd5;
        @(negedge clk); chk_out("br_alu_mem", 0, 0);
        cyc(); mem_rw = 5'd0; ex_regWrite = 1; ex_memRead = 1; ex_rw = 5'd5;
        @(negedge clk); chk_out("br_ld_ex", 1, 0);
        cyc(); ex_regWrite = 0; ex_memRead = 0; ex_rw = 5'd0; mem_memRead = 1; mem_rw = 5'd5;
        @(negedge clk); chk_out("br_ld_mem", 1, 0);
        cyc(); mem_memRead = 0; mem_rw = 5'd0;
        @(negedge clk); chk_out("br_clear", 0, 0);
        cyc(); id_rs = 5'd0; ex_regWrite = 1; ex_rw = 5'd0;
        @(negedge clk); chk_out("br_r0", 0, 0);

        // divide with mflo arriving while busy
        cyc(); clr_in(); md_start = 1; md_is_div = 1;
        @(negedge clk); chk("div_start_busy", 32'(md_busy), 0);
        cyc(); md_start = 0; md_is_div = 0;
        for (int i = 0; i < 31; i++) begin
            id_md_use = (i >= 20);
            @(negedge clk);
            chk("div_busy", 32'(md_busy), 1);
            chk("div_mflo_stall", 32'(stall_id), 32'(i >= 20));
            cyc();
        end
        @(negedge clk);
        chk("div_done_busy", 32'(md_busy), 0);
        chk_out("div_done", 0, 0);
        cyc(); clr_in();
        @(negedge clk); chk("div_idle_busy", 32'(md_busy), 0);

        // multiply, then back-to-back multiply issued in the DONE cycle
        cyc(); md_start = 1;
        @(negedge clk); chk("mul_start_busy", 32'(md_busy), 0);
        cyc(); md_start = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("mul_busy", 32'(md_busy), 1);
            cyc();
        end
        md_start = 1;
        @(negedge clk); chk("mul_done_busy", 32'(md_busy), 0);
        cyc(); md_start = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("b2b_busy", 32'(md_busy), 1);
            cyc();
        end
        @(negedge clk); chk("b2b_done_busy", 32'(md_busy), 0);

        // exception redirect
        cyc(); clr_in(); exc_req = 1;
        @(negedge clk); chk_out("exc_first", 0, 1);
        cyc();
        @(negedge clk); chk_out("exc_hold", 0, 0);
        cyc(); exc_req = 0;
        @(negedge clk); chk_out("exc_off", 0, 0);
        cyc(); exc_req = 1; ex_memRead = 1; ex_rw = 5'd4; id_rs = 5'd4; id_use_rs = 1;
        @(negedge clk); chk_out("exc_hz", 1, 0);
        cyc(); ex_memRead = 0; ex_rw = 5'd0; mem_memRead = 1; mem_rw = 5'd4;
        @(negedge clk); chk_out("exc_after_hz", 0, 1);
        cyc();
        @(negedge clk); chk_out("exc_after_hold", 0, 0);

        // reset in the middle of a divide (counter at 17)
        cyc(); clr_in(); md_start = 1; md_is_div = 1;
        cyc(); md_start = 0; md_is_div = 0;
        repeat (14) cyc();
        id_md_use = 1; exc_req = 1;
        @(negedge clk);
        chk("mid_div_busy", 32'(md_busy), 1);
        chk_out("mid_div", 1, 0);
        #2 rst = 1'b0;
        #1;
        chk("rst_abort_busy", 32'(md_busy), 0);
        chk_out("rst_abort", 0, 0);
`ifdef HAZARD_PERF_EN
        chk("rst_abort_stall_cnt", stall_cnt, 0);
`endif
        cyc(); rst = 1'b1; exc_req = 0;
        @(negedge clk);
        chk("post_rst_busy", 32'(md_busy), 0);
        chk_out("post_rst", 0, 0);
        cyc(); id_md_use = 0; md_start = 1;
        @(negedge clk); chk("post_rst_mul0", 32'(md_busy), 0);
        cyc(); md_start = 0; exc_req = 1;
        @(negedge clk);
        chk("post_rst_mul1", 32'(md_busy), 1);
        chk_out("post_rst_exc", 0, 1);
        cyc(); clr_in();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush scheduler for the 5-stage pipeline. It detects load-use and branch-in-ID operand hazards that forwarding cannot cover, and sequences the multi-cycle multiply/divide unit (MDU). It also orders exception/ERET redirect flushes. It drives stall_if/stall_id into IF and the IF/ID register, and the bubble (ID_FLUSH) into the ID/EX register.

Parameters:
MUL_CYCLES, 4, MDU latency for multiply in cycles (>=2)
DIV_CYCLES, 32, MDU latency for divide in cycles (>=2)
CNT_W, 6, MDU countdown width; must hold max(MUL_CYCLES,DIV_CYCLES)-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of instr in ID
id_rt  in  5  rt field of instr in ID
id_use_rs  in  1  ID instr reads rs
id_use_rt  in  1  ID instr reads rt
id_is_branch  in  1  ID instr resolves in ID (branch, jr, jalr)
id_md_use  in  1  ID instr is mul/div/mfhi/mflo/mthi/mtlo
ex_rw  in  5  destination reg of instr in EX
ex_regWrite  in  1  EX instr writes GPR
ex_memRead  in  1  EX instr is a load
mem_rw  in  5  destination reg of instr in MEM
mem_memRead  in  1  MEM instr is a load
md_start  in  1  EX issues an MDU op this cycle
md_is_div  in  1  qualifies md_start: 1=divide, 0=multiply
exc_req  in  1  ID raises exception entry or ERET redirect
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID register
flush_ex  out  1  insert bubble into ID/EX (clear EX/MEM/WB ctrl)
flush_id  out  1  clear IF/ID register (kill fetched instr)
md_busy  out  1  MDU result not yet available

Behaviour:
- Reset (rst=0, async): MDU FSM=MD_IDLE, counter=0, exception FSM=EX_NORM. All outputs are 0 immediately.
- Register 0 never creates a hazard. A match requires the read enable and rs/rt == rw != 0.
- hz_load (combinational): ex_memRead && match(ex_rw).
- hz_branch (combinational): id_is_branch && ((ex_regWrite && match(ex_rw)) || (mem_memRead && match(mem_rw))).
- hz_md (combinational): id_md_use && md_busy.
- hazard = hz_load | hz_branch | hz_md.
- Stall output: stall_if = stall_id = flush_ex = hazard && !flush_id.
- MDU FSM:
  - MD_IDLE: md_start -> MD_BUSY, counter = (md_is_div ? DIV_CYCLES : MUL_CYCLES) - 1.
  - MD_BUSY: counter decrements each cycle. When counter==1 -> MD_DONE.
  - MD_DONE: lasts one cycle -> MD_IDLE. md_start here is legal and goes directly to MD_BUSY (back-to-back).
  - md_busy = 1 in MD_BUSY, 0 in MD_IDLE/MD_DONE. md_busy is registered: it asserts the cycle after md_start and stays high for exactly N-1 cycles.
  - md_start while MD_BUSY is ignored. The hz_md stall guarantees this cannot legally occur.
- Exception FSM:
  - EX_NORM: exc_req && !hazard -> flush_id=1 (combinational, same cycle) and go to EX_HOLD.
  - EX_HOLD: flush_id=0; exc_req ignored; -> EX_NORM next cycle. This suppresses a duplicate redirect from a re-presented instruction.
  - exc_req together with hazard: the stall takes priority, flush_id=0, and the FSM stays in EX_NORM. The request is re-evaluated once operands clear.
- Simultaneous flush_id and hazard cannot occur by construction. flush_id forces stall_*=0 so that the redirect PC is accepted.
- Latency: all stall/flush outputs are same-cycle combinational from inputs plus registered FSM state. No output depends on itself combinationally.
- Reset asserted mid-MDU-op aborts the op: md_busy=0 asynchronously.

Optional Feature:
HAZARD_PERF_EN:
- Defined: adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt counts cycles with stall_id=1.
  - flush_cnt counts cycles with flush_id=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Load-use: EX lw $3 (ex_memRead=1, ex_rw=3); ID add reads rs=3 -> stall_if=stall_id=flush_ex=1 for exactly 1 cycle, then 0 once the lw moves to MEM.
2. Branch: beq rs=5 in ID with an ALU write to $5 in EX -> stall 1 cycle. Repeat with lw $5 in EX -> stall 2 cycles (EX, then MEM). Repeat with rw=0 -> no stall.
3. MDU: md_start with md_is_div=1 -> md_busy high 31 cycles from the next edge. A mflo in ID during that time -> stall for the remaining busy cycles and released on the MD_DONE cycle. Multiply -> md_busy high 3 cycles.
4. Back-to-back MDU: md_start asserted in the MD_DONE cycle -> md_busy drops for only that cycle, then re-asserts for the new count.
5. Exception: exc_req=1 held 2 cycles with no hazard -> flush_id=1 in the first cycle only. With exc_req and hz_load together -> flush_id=0, stall=1, then flush_id=1 in the following cycle.
6. Reset: assert rst=0 mid-divide (counter=17) -> md_busy and all outputs 0 without a clock edge. After release, FSMs are idle. With HAZARD_PERF_EN, stall_cnt=0.
